// File: rtl/seq_list_scheduler_if.sv
// seq_list_scheduler_if
//   Signal bundle between the sequence list scheduler, the system state-machine
//   controller (frame strobe, enable vector) and the shared sequence executor.
//   master : the scheduler side (drives start/id/status, samples requests)
//   slave  : the controller/executor side
//   Parameters: LS  - number of sequence list entries
//               IDW - width of the sequence index
`timescale 1ns/1ps
interface seq_list_scheduler_if #(
  parameter int LS  = 36,
  parameter int IDW = 6
);
  logic           enable;
  logic           sys_tmr_strb;
  logic [LS-1:0]  seq_list_en;
  logic           seq_done_strb;
  logic           seq_start_strb;
  logic [IDW-1:0] seq_id;
  logic           seq_list_done_strb;
  logic           frame_active;
  logic           timeout_strb;
  logic           overrun_strb;
  logic [7:0]     overrun_cnt;

  modport master (
    input  enable, sys_tmr_strb, seq_list_en, seq_done_strb,
    output seq_start_strb, seq_id, seq_list_done_strb, frame_active,
           timeout_strb, overrun_strb, overrun_cnt
  );

  modport slave (
    output enable, sys_tmr_strb, seq_list_en, seq_done_strb,
    input  seq_start_strb, seq_id, seq_list_done_strb, frame_active,
           timeout_strb, overrun_strb, overrun_cnt
  );
endinterface

// File: rtl/seq_list_scheduler.sv
// seq_list_scheduler
//   Latches the per-frame sequence enable vector on each system timer strobe and
//   issues every enabled sequence to the shared executor, lowest index first,
//   waiting for each done (or a timeout) before issuing the next.
//   Ports:
//     clk     - system clock
//     reset_n - asynchronous active-low reset
//     bus     - scheduler side of seq_list_scheduler_if (frame strobe, enable,
//               enable vector, executor handshake, frame/timeout/overrun status)
//   All outputs are registered.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame in progress, waiting for sys_tmr_strb && enable
//   SCAN  | pick lowest pending entry, or finish the frame
//   ISSUE | start pulse to executor, timeout counter cleared
//   WAIT  | waiting for seq_done_strb or timeout
//   DONE  | list-done pulse, frame_active drops
`timescale 1ns/1ps
module seq_list_scheduler #(
  parameter int               LS      = 36,
  parameter int               IDW     = 6,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_list_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // WAIT lasts TMO_MAX cycles: counter reads 0 in the first WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;
  localparam logic [LS-1:0]    ONE_LS   = {{(LS-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [LS-1:0]    pending_q, pending_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [IDW-1:0]   seq_id_q, seq_id_d;
  logic             start_q, start_d;
  logic             list_done_q, list_done_d;
  logic             frame_active_q, frame_active_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       overrun_cnt_q, overrun_cnt_d;

  logic             hit;
  logic [IDW-1:0]   hit_idx;

  // Lowest set bit wins: scan downward so the last match is the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = LS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        hit     = 1'b1;
        hit_idx = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    tmo_cnt_d      = tmo_cnt_q;
    seq_id_d       = seq_id_q;
    start_d        = 1'b0;
    list_done_d    = 1'b0;
    frame_active_d = frame_active_q;
    timeout_d      = 1'b0;

    // A strobe outside IDLE never restarts the frame; it is only counted.
    overrun_d     = bus.sys_tmr_strb && (state_q != S_IDLE);
    overrun_cnt_d = overrun_cnt_q;
    if (overrun_d && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_d = overrun_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.sys_tmr_strb && bus.enable) begin
          pending_d      = bus.seq_list_en;
          frame_active_d = 1'b1;
          state_d        = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!hit || !bus.enable) begin
          // Disabling drops whatever is left of this frame's list.
          pending_d   = '0;
          list_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          seq_id_d  = hit_idx;
          pending_d = pending_q & (pending_q - ONE_LS);
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.seq_done_strb) begin
          state_d = S_SCAN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_SCAN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        frame_active_d = 1'b0;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      pending_q      <= '0;
      tmo_cnt_q      <= '0;
      seq_id_q       <= '0;
      start_q        <= 1'b0;
      list_done_q    <= 1'b0;
      frame_active_q <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
      overrun_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      tmo_cnt_q      <= tmo_cnt_d;
      seq_id_q       <= seq_id_d;
      start_q        <= start_d;
      list_done_q    <= list_done_d;
      frame_active_q <= frame_active_d;
      timeout_q      <= timeout_d;
      overrun_q      <= overrun_d;
      overrun_cnt_q  <= overrun_cnt_d;
    end
  end

  assign bus.seq_start_strb     = start_q;
  assign bus.seq_id             = seq_id_q;
  assign bus.seq_list_done_strb = list_done_q;
  assign bus.frame_active       = frame_active_q;
  assign bus.timeout_strb       = timeout_q;
  assign bus.overrun_strb       = overrun_q;
  assign bus.overrun_cnt        = overrun_cnt_q;

endmodule

// File: tb/tb_seq_list_scheduler.sv
// tb_seq_list_scheduler
//   Scoreboard bench: expected start/id, timeout, overrun and list-done events
//   are queued with their cycle numbers when a frame is launched, and popped
//   and compared by a negedge monitor as the scheduler produces them.
`timescale 1ns/1ps
module tb_seq_list_scheduler;
  localparam int LS    = 36;
  localparam int IDW   = 6;
  localparam int TMO_W = 16;
  localparam int TMO   = 8;

  typedef struct {
    int unsigned    cyc;
    logic [IDW-1:0] id;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_list_scheduler_if #(.LS(LS), .IDW(IDW)) bus ();

  seq_list_scheduler #(
    .LS(LS), .IDW(IDW), .TMO_W(TMO_W), .TMO_MAX(16'd8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  ev_t         start_q[$];
  int unsigned done_q[$];
  int unsigned tmo_q[$];
  int unsigned ovr_q[$];
  logic        sb_off = 1'b0;
  int          exec_lat = 0;
  int unsigned done_due = 32'hFFFF_FFFF;

  logic e_s, e_d, e_t, e_o;

  // Monitor: every cycle each strobe must match whether an event is due now.
  always @(negedge clk) begin
    if (reset_n && !sb_off) begin
      e_s = (start_q.size() > 0) && (start_q[0].cyc == cyc);
      check_val("start_strb", bus.seq_start_strb, e_s);
      if (e_s) begin
        check_val("seq_id", bus.seq_id, start_q[0].id);
        void'(start_q.pop_front());
      end
      e_d = (done_q.size() > 0) && (done_q[0] == cyc);
      check_val("list_done_strb", bus.seq_list_done_strb, e_d);
      if (e_d) void'(done_q.pop_front());
      e_t = (tmo_q.size() > 0) && (tmo_q[0] == cyc);
      check_val("timeout_strb", bus.timeout_strb, e_t);
      if (e_t) void'(tmo_q.pop_front());
      e_o = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
      check_val("overrun_strb", bus.overrun_strb, e_o);
      if (e_o) void'(ovr_q.pop_front());
      if (bus.seq_start_strb && exec_lat > 0) done_due = cyc + exec_lat;
    end
  end

  // Executor model: one-cycle done pulse exec_lat cycles after each start.
  initial begin
    bus.seq_done_strb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.seq_done_strb = (cyc == done_due);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    start_q.delete();
    done_q.delete();
    tmo_q.delete();
    ovr_q.delete();
  endtask

  // Queue the whole expected schedule for one frame, then strobe it in.
  task automatic launch_frame(input logic [LS-1:0] list, input int lat);
    int unsigned c0, per, k, s;
    bit          tmo_path;
    c0       = cyc;
    exec_lat = lat;
    tmo_path = !(lat >= 1 && lat <= TMO);
    per      = tmo_path ? TMO + 2 : lat + 2;
    k        = 0;
    for (int i = 0; i < LS; i++) begin
      if (list[i]) begin
        s = c0 + 2 + k * per;
        start_q.push_back('{s, IDW'(i)});
        if (tmo_path) tmo_q.push_back(s + TMO + 1);
        k++;
      end
    end
    done_q.push_back(c0 + 2 + k * per);
    bus.seq_list_en  = list;
    bus.sys_tmr_strb = 1'b1;
    step();
    bus.sys_tmr_strb = 1'b0;
  endtask

  task automatic drain();
    int b;
    int left;
    b = 0;
    while ((start_q.size() + done_q.size() + tmo_q.size() + ovr_q.size()) != 0 && b < 3000) begin
      step();
      b++;
    end
    left = start_q.size() + done_q.size() + tmo_q.size() + ovr_q.size();
    check_val("drain_events_left", left, 0);
    repeat (3) step();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_start"},     bus.seq_start_strb, 0);
    check_val({pfx, "_seq_id"},    bus.seq_id, 0);
    check_val({pfx, "_list_done"}, bus.seq_list_done_strb, 0);
    check_val({pfx, "_frame_act"}, bus.frame_active, 0);
    check_val({pfx, "_timeout"},   bus.timeout_strb, 0);
    check_val({pfx, "_overrun"},   bus.overrun_strb, 0);
    check_val({pfx, "_ovr_cnt"},   bus.overrun_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected run to end earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    bus.enable       = 1'b0;
    bus.sys_tmr_strb = 1'b0;
    bus.seq_list_en  = '0;
    reset_n          = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    repeat (2) step();

    // Two entries, executor done 3 cycles after each start.
    launch_frame(36'h0_0000_0012, 3);
    drain();

    // Empty list: done in cycle 2, frame_active high in cycles 1-2 only.
    launch_frame('0, 3);
    check_val("empty_fa_c1", bus.frame_active, 1);
    step();
    check_val("empty_fa_c2", bus.frame_active, 1);
    step();
    check_val("empty_fa_c3", bus.frame_active, 0);
    drain();

    // Timeout with no done, then done in the final WAIT cycle.
    launch_frame(36'h0_0000_0080, 0);
    drain();
    launch_frame(36'h0_0000_0080, TMO);
    drain();

    // Multi-entry frame with timeouts and a spread of indices.
    launch_frame(36'h8_0000_0401, 0);
    drain();
    launch_frame(36'h8_4000_0001, 2);
    drain();

    // Overrun in WAIT: frame continues, new vector not latched.
    launch_frame(36'h0_0000_0080, 5);
    c0 = cyc - 1;
    step();
    step();
    bus.seq_list_en  = 36'hF_FFFF_FFFF;
    bus.sys_tmr_strb = 1'b1;
    ovr_q.push_back(c0 + 4);
    step();
    bus.sys_tmr_strb = 1'b0;
    bus.seq_list_en  = '0;
    drain();
    check_val("overrun_cnt_one", bus.overrun_cnt, 1);

    // Continuous strobes: counter must saturate.
    sb_off           = 1'b1;
    bus.seq_list_en  = '0;
    bus.sys_tmr_strb = 1'b1;
    repeat (500) step();
    bus.sys_tmr_strb = 1'b0;
    repeat (5) step();
    check_val("overrun_cnt_sat", bus.overrun_cnt, 8'hFF);
    clear_sb();
    sb_off = 1'b0;
    step();

    // Enable dropped while 4 runs: 8 and 9 never start.
    exec_lat = 3;
    c0       = cyc;
    start_q.push_back('{c0 + 2, IDW'(4)});
    done_q.push_back(c0 + 7);
    bus.seq_list_en  = 36'h0_0000_0310;
    bus.sys_tmr_strb = 1'b1;
    step();
    bus.sys_tmr_strb = 1'b0;
    step();
    step();
    bus.enable = 1'b0;
    drain();
    bus.enable = 1'b1;
    step();

    // Async reset mid-WAIT, then a fresh frame.
    launch_frame(36'h0_0000_0010, 0);
    repeat (3) step();
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    clear_sb();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (4) step();
    check_val("post_rst_fa", bus.frame_active, 0);
    launch_frame(36'h0_0000_0012, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
